// File: rtl/divider16b.sv
// Sequential 16-bit unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional macro DIVIDER16B_DBZ_FLAG_EN enables the registered divide-by-zero flag.
module divider16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] q,
  output logic [15:0] r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [15:0] r_dvd;
  logic [15:0] r_dvs;
  logic [16:0] r_rem;
  logic [15:0] r_quo;
  logic [3:0]  r_cnt;
  logic [15:0] r_q;
  logic [15:0] r_r;

  logic [16:0] w_rem17;
  logic [16:0] w_diff;
  logic        w_qbit;
  logic [16:0] w_remNext;
  logic [15:0] w_quoNext;

  // A zero divisor never borrows, so it naturally yields all-ones quotient and r = x.
  assign w_rem17   = {r_rem[15:0], r_dvd[15]};
  assign w_diff    = w_rem17 - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[16];
  assign w_remNext = w_qbit ? w_diff : w_rem17;
  assign w_quoNext = {r_quo[14:0], w_qbit};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign q         = r_q;
  assign r         = r_r;

`ifdef DIVIDER16B_DBZ_FLAG_EN
  logic r_dbzIn;
  logic r_dbz;
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
`ifdef DIVIDER16B_DBZ_FLAG_EN
      r_dbzIn <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd   <= x;
            r_dvs   <= y;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
`ifdef DIVIDER16B_DBZ_FLAG_EN
            r_dbzIn <= (y == 16'd0);
`endif
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          r_dvd <= {r_dvd[14:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          // Results are copied out only on the final iteration so q/r stay stable during BUSY.
          if (r_cnt == 4'd15) begin
            r_q     <= w_quoNext;
            r_r     <= w_remNext[15:0];
`ifdef DIVIDER16B_DBZ_FLAG_EN
            r_dbz   <= r_dbzIn;
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/divider16b.md
# divider16b

Sequential 16-bit unsigned integer divider. It computes quotient and remainder of a 16-bit dividend by a 16-bit divisor using radix-2 restoring division, one quotient bit per clock. It is the inverse-operation companion of the combinational `multiplier16b` in the same arithmetic library. It uses a valid/ready handshake on both input and output so it can sit directly in a datapath pipeline.

## Interface

**Parameters:** none. Width is fixed at 16.

**Ports** (name, direction, width, meaning):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `x` input 16: dividend, unsigned. Sampled only on input handshake.
- `y` input 16: divisor, unsigned. Sampled only on input handshake.
- `in_valid` input 1: the `x`/`y` operand pair is valid.
- `in_ready` output 1: the block can accept operands. High only in IDLE.
- `q` output 16: quotient, floor(x/y).
- `r` output 16: remainder, x − q·y.
- `out_valid` output 1: `q` and `r` hold a finished result.
- `out_ready` input 1: the consumer accepts the result.
- `div_by_zero` output 1: the divisor was zero. Driven 0 unless `DIVIDER16B_DBZ_FLAG_EN` is defined.

## Operation

**State machine:** IDLE, BUSY, DONE.
- **IDLE:** `in_ready`=1.
  - On `in_valid`&`in_ready`, latch `x` into the dividend shift register and `y` into the divisor register.
  - Clear the 17-bit partial remainder and the 4-bit iteration counter.
  - Go to BUSY.
- **BUSY:** `in_ready`=0. Each cycle performs one iteration:
  - `rem17 = {rem[15:0], dvd[15]}`
  - `diff = rem17 − {1'b0, y}` (17-bit)
  - If `diff[16]`==0: `rem = diff` and qbit=1. Otherwise keep `rem17` and qbit=0.
  - Shift `dvd` left by 1 and shift qbit into the quotient LSB.
  - The counter increments each iteration. When the counter is 15 (the 16th iteration), go to DONE.
- **DONE:** `out_valid`=1.
  - `q`/`r` are driven from registers.
  - On `out_ready`, go to IDLE. `out_valid` drops on the same edge.

**Operand and output rules:**
- Changes on `x`, `y`, or `in_valid` outside IDLE are ignored.
- `q`, `r`, and `div_by_zero` are stable for the whole time `out_valid`=1. They retain their last values after the handshake until the next result is loaded.

**Arithmetic:**
- All operations are unsigned. Internal partial remainder is 17 bits. The final remainder is `rem[15:0]`, and always r < y when y≠0.
- **Divide by zero (y=0):** every iteration yields qbit=1. Result is `q`=16'hFFFF, `r`=`x`, with no special-casing in the datapath.

**Boundaries:**
- **Reset at any time** (including mid-BUSY or DONE): state returns to IDLE immediately and the partial result is discarded.
- **Simultaneous `in_valid` in DONE:** not accepted, because `in_ready`=0.
- **No bypass:** there is no back-to-back overlap. A new operand pair is accepted only after the DONE handshake.

## Timing

- **Reset values:** `in_ready`=1, `out_valid`=0, `q`=0, `r`=0, `div_by_zero`=0. State is IDLE and the counter is 0.
- **Latency:** the input handshake occurs on edge E0. The 16 iterations occur on edges E1..E16. `out_valid` is high after E16, so the result is available 16 cycles after acceptance.
- **Throughput:** minimum 18 cycles per operation with `out_ready` held high: accept, 16 × BUSY, DONE. `in_ready` rises after the DONE handshake edge.
- **Backpressure:** DONE persists indefinitely while `out_ready`=0.
- **Output timing:** all outputs are registered or decoded from state only, with no combinational path from inputs to outputs.

## Configuration

- **`DIVIDER16B_DBZ_FLAG_EN` defined:**
  - The `y`==0 comparison is registered at the input handshake.
  - `div_by_zero` equals that flag while `out_valid`=1 and holds after the handshake until the next result.
  - `q`/`r` are still 16'hFFFF/`x`.
- **Not defined:**
  - No comparator or flag register.
  - `div_by_zero` is tied to 0.
  - Divide-by-zero results are unchanged (16'hFFFF/`x`).

## Test plan

- Reset, then `x`=100, `y`=7 accepted at E0. Expect `out_valid` high after E16 (not before), `q`=14, `r`=2, and `in_ready`=0 throughout BUSY and DONE.
- Extremes: 16'hFFFF/1 gives `q`=16'hFFFF, `r`=0. 3/16'hFFFF gives `q`=0, `r`=3. 16'hFFFF/16'hFFFF gives `q`=1, `r`=0.
- `x`=5, `y`=0. Expect `q`=16'hFFFF, `r`=5. `div_by_zero`=1 with the macro defined, 0 without it.
- Hold `out_ready`=0 for 5 cycles in DONE while toggling `x`/`y`/`in_valid`. Expect `q`/`r`/`out_valid` stable and no new acceptance. Raise `out_ready`: `out_valid` falls next edge and `in_ready` rises.
- Assert `rst` asynchronously during the 8th BUSY iteration of 1000/3. Expect `out_valid`=0, `q`=`r`=0, `in_ready`=1 immediately. A subsequent 1000/3 yields `q`=333, `r`=1.
